// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the write-port arbiter state encoding.
package fb_pkg;

  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned FB_WIDTH     = 160;
  localparam int unsigned FB_HEIGHT    = 120;
  localparam int unsigned TOTAL_PIXELS = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fb_idle_watchdog.sv
// Counts consecutive idle cycles of the current grant owner; expired fires on the cycle
// that would bring the count to LIMIT.
module fb_idle_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  assign expired = enable && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Round-robin burst arbiter in front of the framebuffer RAM write port, with address
// range filtering and an idle-owner watchdog.
module fb_wr_arbiter #(
  parameter int unsigned ADDR_W       = fb_pkg::ADDR_W,
  parameter int unsigned DATA_W       = fb_pkg::DATA_W,
  parameter int unsigned TOTAL_PIXELS = fb_pkg::TOTAL_PIXELS,
  parameter int unsigned IDLE_LIMIT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              err_range,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] beat_count
);

  import fb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic              burst_done_q, burst_done_d;
  logic              acc0, acc1, accepted;
  logic              last_sel, own_req;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic              in_range, wr_en;
  logic              wd_enable, wd_clear, wd_expired;
  logic              evict, release_own;

  logic              ram_wren_q;
  logic [ADDR_W-1:0] ram_wraddr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              err_range_q, err_timeout_q;
  logic [ADDR_W-1:0] beat_count_q;

  assign acc0     = req0 && (state_q == StOwn0);
  assign acc1     = req1 && (state_q == StOwn1);
  assign accepted = acc0 || acc1;
  assign addr_sel = acc1 ? addr1 : addr0;
  assign data_sel = acc1 ? data1 : data0;
  assign last_sel = acc1 ? last1 : last0;
  assign own_req  = (state_q == StOwn1) ? req1 : req0;

  assign in_range = addr_sel < ADDR_W'(TOTAL_PIXELS);
  assign wr_en    = accepted && in_range;

  // Once a burst has ended the owner keeps the grant only while it immediately
  // re-requests; dropping req at a burst boundary releases the port without a timeout.
  assign release_own = (state_q != StIdle) && !own_req && burst_done_q;
  assign evict       = (state_q != StIdle) && !burst_done_q && wd_expired;

  assign wd_enable = (state_q != StIdle) && !own_req;
  assign wd_clear  = accepted || (state_d != state_q);

  fb_idle_watchdog #(
    .LIMIT (IDLE_LIMIT)
  ) u_idle_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = rr_q ? StOwn1 : StOwn0;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (acc0 && last0) begin
          rr_d    = 1'b1;
          state_d = req1 ? StOwn1 : StOwn0;
        end else if (release_own || evict) begin
          rr_d    = 1'b1;
          state_d = req1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (acc1 && last1) begin
          rr_d    = 1'b0;
          state_d = req0 ? StOwn0 : StOwn1;
        end else if (release_own || evict) begin
          rr_d    = 1'b0;
          state_d = req0 ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    burst_done_d = burst_done_q;
    if (accepted) begin
      burst_done_d = last_sel;
    end
    if (state_d != state_q) begin
      burst_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_q          <= 1'b0;
      burst_done_q  <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_wraddr_q  <= '0;
      ram_data_q    <= '0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      beat_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      burst_done_q <= burst_done_d;
      ram_wren_q   <= wr_en;
      if (wr_en) begin
        ram_wraddr_q <= addr_sel;
        ram_data_q   <= data_sel;
        beat_count_q <= beat_count_q + ADDR_W'(1);
      end
      if (accepted && !in_range) begin
        err_range_q <= 1'b1;
      end
      if (evict) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign gnt0        = (state_q == StOwn0);
  assign gnt1        = (state_q == StOwn1);
  assign busy        = gnt0 || gnt1;
  assign ram_wren    = ram_wren_q;
  assign ram_wraddr  = ram_wraddr_q;
  assign ram_data    = ram_data_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;
  assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Directed self-checking bench for fb_wr_arbiter; inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_fb_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, last0, last1;
  logic [18:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        gnt0, gnt1, ram_wren, busy, err_range, err_timeout;
  logic [18:0] ram_wraddr, beat_count;
  logic [7:0]  ram_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_wr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .addr0       (addr0),
    .data0       (data0),
    .last0       (last0),
    .req1        (req1),
    .addr1       (addr1),
    .data1       (data1),
    .last1       (last1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .ram_wraddr  (ram_wraddr),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .err_range   (err_range),
    .err_timeout (err_timeout),
    .beat_count  (beat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; addr0 = '0; data0 = '0; last0 = 0;
    req1 = 0; addr1 = '0; data1 = '0; last1 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req0 = 1; req1 = 1;
    reset = 1;
    tick();
    tick();
    total++; if ({gnt0, gnt1, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_gnt: got %b want 000", {gnt0, gnt1, busy}); end
    total++; if ({ram_wren, err_range, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {ram_wren, err_range, err_timeout}); end
    total++; if (ram_wraddr !== 19'd0 || ram_data !== 8'd0 || beat_count !== 19'd0) begin
      bad++; $display("FAIL reset_data: got %0d/%0h/%0d want 0/0/0",
                      ram_wraddr, ram_data, beat_count); end
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_single_burst();
    do_reset();
    req0 = 1; addr0 = 19'd0; data0 = 8'hA0; last0 = 0;
    total++; if (gnt0 !== 1'b0) begin
      bad++; $display("FAIL single_pre_gnt: got %b want 0", gnt0); end
    tick();
    total++; if (gnt0 !== 1'b1) begin
      bad++; $display("FAIL single_gnt_latency: got %b want 1", gnt0); end
    for (int i = 0; i < 4; i++) begin
      addr0 = 19'(i); data0 = 8'hA0 + 8'(i); last0 = (i == 3);
      tick();
      total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'(i) || ram_data !== 8'hA0 + 8'(i)) begin
        bad++; $display("FAIL single_write%0d: got wren=%b addr=%0d data=%0h want 1/%0d/%0h",
                        i, ram_wren, ram_wraddr, ram_data, i, 8'hA0 + 8'(i)); end
      total++; if (beat_count !== 19'(i + 1)) begin
        bad++; $display("FAIL single_count%0d: got %0d want %0d", i, beat_count, i + 1); end
    end
    req0 = 0; last0 = 0;
    tick();
    total++; if (busy !== 1'b0 || ram_wren !== 1'b0) begin
      bad++; $display("FAIL single_idle: got busy=%b wren=%b want 0/0", busy, ram_wren); end
    total++; if (beat_count !== 19'd4 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL single_final: got count=%0d tmo=%b want 4/0", beat_count, err_timeout); end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1; addr0 = 19'd100; data0 = 8'h11; last0 = 0;
    req1 = 1; addr1 = 19'd200; data1 = 8'h22; last1 = 1;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b10) begin
      bad++; $display("FAIL cont_first: got %b want 10", {gnt0, gnt1}); end
    tick();
    addr0 = 19'd101; data0 = 8'h12; last0 = 1;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b01) begin
      bad++; $display("FAIL cont_handover: got %b want 01", {gnt0, gnt1}); end
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd101) begin
      bad++; $display("FAIL cont_last0_write: got %b/%0d want 1/101", ram_wren, ram_wraddr); end
    addr0 = 19'd102; data0 = 8'h13; last0 = 1;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b10 || ram_wraddr !== 19'd200 || ram_data !== 8'h22) begin
      bad++; $display("FAIL cont_back_to_0: got gnt=%b addr=%0d data=%0h want 10/200/22",
                      {gnt0, gnt1}, ram_wraddr, ram_data); end
    req1 = 0;
    tick();
    req0 = 0;
    tick();
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL cont_idle: got %b want 0", busy); end
    req0 = 1; req1 = 1; last0 = 0; last1 = 0;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b01) begin
      bad++; $display("FAIL cont_rr_idle: got %b want 01", {gnt0, gnt1}); end
  endtask

  task automatic test_range_filter();
    do_reset();
    req0 = 1; addr0 = 19'd19199; data0 = 8'h01; last0 = 0;
    tick();
    tick();
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd19199) begin
      bad++; $display("FAIL range_max_ok: got %b/%0d want 1/19199", ram_wren, ram_wraddr); end
    addr0 = 19'd19200; data0 = 8'h02;
    tick();
    total++; if (ram_wren !== 1'b0 || err_range !== 1'b1) begin
      bad++; $display("FAIL range_drop: got wren=%b err=%b want 0/1", ram_wren, err_range); end
    addr0 = 19'd0; data0 = 8'h03; last0 = 1;
    tick();
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd0 || ram_data !== 8'h03) begin
      bad++; $display("FAIL range_continue: got %b/%0d/%0h want 1/0/03",
                      ram_wren, ram_wraddr, ram_data); end
    req0 = 0; last0 = 0;
    tick();
    tick();
    total++; if (err_range !== 1'b1 || beat_count !== 19'd2) begin
      bad++; $display("FAIL range_sticky: got err=%b count=%0d want 1/2", err_range, beat_count); end
  endtask

  task automatic test_watchdog();
    do_reset();
    req0 = 1; addr0 = 19'd5; data0 = 8'h55; last0 = 0;
    req1 = 1; addr1 = 19'd7; data1 = 8'h77; last1 = 0;
    tick();
    tick();
    req0 = 0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (gnt0 !== 1'b1 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_before: got gnt0=%b tmo=%b want 1/0", gnt0, err_timeout); end
    tick();
    total++; if ({gnt0, gnt1} !== 2'b01 || err_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_evict: got gnt=%b tmo=%b want 01/1", {gnt0, gnt1}, err_timeout); end

    do_reset();
    req0 = 1; addr0 = 19'd5; data0 = 8'h55; last0 = 0;
    tick();
    tick();
    req0 = 0; req1 = 1;
    for (int i = 0; i < 15; i++) tick();
    req0 = 1; addr0 = 19'd6; data0 = 8'h66;
    tick();
    total++; if (gnt0 !== 1'b1 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL wd_no_evict: got gnt0=%b tmo=%b want 1/0", gnt0, err_timeout); end
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd6) begin
      bad++; $display("FAIL wd_late_beat: got %b/%0d want 1/6", ram_wren, ram_wraddr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0 = 1; addr0 = 19'd30; data0 = 8'h30; last0 = 1;
    tick();
    tick();
    total++; if (gnt0 !== 1'b1 || ram_wren !== 1'b1 || ram_wraddr !== 19'd30) begin
      bad++; $display("FAIL b2b_hold: got gnt0=%b wren=%b addr=%0d want 1/1/30",
                      gnt0, ram_wren, ram_wraddr); end
    addr0 = 19'd31; data0 = 8'h31; last0 = 0;
    tick();
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd31 || gnt0 !== 1'b1) begin
      bad++; $display("FAIL b2b_nogap: got wren=%b addr=%0d gnt0=%b want 1/31/1",
                      ram_wren, ram_wraddr, gnt0); end
    addr0 = 19'd32; data0 = 8'h32; last0 = 1; req1 = 1;
    tick();
    total++; if ({gnt0, gnt1} !== 2'b01 || beat_count !== 19'd3) begin
      bad++; $display("FAIL b2b_pass: got gnt=%b count=%0d want 01/3", {gnt0, gnt1}, beat_count); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1; addr0 = 19'd40; data0 = 8'h40; last0 = 0;
    tick();
    tick();
    addr0 = 19'd41; data0 = 8'h41;
    reset = 1;
    tick();
    total++; if (ram_wren !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || beat_count !== 19'd0) begin
      bad++; $display("FAIL midrst_state: got wren=%b gnt0=%b busy=%b count=%0d want 0/0/0/0",
                      ram_wren, gnt0, busy, beat_count); end
    reset = 0;
    addr0 = 19'd40; data0 = 8'h40;
    tick();
    total++; if (gnt0 !== 1'b1 || ram_wren !== 1'b0) begin
      bad++; $display("FAIL midrst_regrant: got gnt0=%b wren=%b want 1/0", gnt0, ram_wren); end
    tick();
    total++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'd40 || beat_count !== 19'd1) begin
      bad++; $display("FAIL midrst_restart: got %b/%0d/%0d want 1/40/1",
                      ram_wren, ram_wraddr, beat_count); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single_burst();
    test_contention();
    test_range_filter();
    test_watchdog();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_wr_arbiter.md
# fb_wr_arbiter

Write-port arbiter for the 160x120 8-bit framebuffer RAM. Two requesters share the single RAM write port: requester 0 is the ROM-to-RAM image loader and requester 1 is the pixel-processing engine. Bursts are granted round-robin and never interrupted, out-of-range addresses are filtered, and a stalled owner is evicted by a watchdog. It sits directly in front of the RAM write port, and all RAM writes in the design pass through it.

## Interface

Parameters:
- ADDR_W, 19, RAM address width
- DATA_W, 8, pixel width
- TOTAL_PIXELS, 19200, number of valid addresses (160*120); valid range is 0..TOTAL_PIXELS-1
- IDLE_LIMIT, 16, consecutive idle cycles an owner may hold a grant before eviction

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  beat valid from requester 0 / 1
- addr0, addr1  in  ADDR_W  beat write address
- data0, data1  in  DATA_W  beat write data
- last0, last1  in  1  beat is the final beat of its burst
- gnt0, gnt1  out  1  grant to requester 0 / 1; at most one is high (registered)
- ram_wraddr  out  ADDR_W  RAM write address
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- busy  out  1  high when a grant is held
- err_range  out  1  sticky; set by any accepted beat with addr >= TOTAL_PIXELS
- err_timeout  out  1  sticky; set by a watchdog eviction
- beat_count  out  ADDR_W  count of RAM writes performed since reset; wraps at 2^ADDR_W

## Operation

- States: IDLE, OWN0, OWN1. The outputs are derived as gnt0 = (state==OWN0), gnt1 = (state==OWN1), and busy = gnt0|gnt1.
- A beat is accepted in a cycle where reqN && gntN.
- IDLE:
  - If only one requester asserts req, go to that requester's OWN state.
  - If both assert req, go to OWN of the round-robin pointer rr.
  - rr resets to 0.
- OWNn:
  - On an accepted beat with lastn, set rr to the other requester.
  - Next state on that last beat: OWN(other) if the other's req is high; else OWNn if reqn is high (back-to-back burst); else IDLE.
- Watchdog:
  - An idle counter increments in OWNn for each cycle with reqn low, and clears on any accepted beat or on a state change.
  - When it reaches IDLE_LIMIT: set err_timeout, set rr to the other requester, then go to OWN(other) if its req is high, else IDLE.
- Range filter: an accepted beat with addr < TOTAL_PIXELS produces a RAM write. Otherwise no write occurs, err_range is set, and the burst continues.
- Requesters hold addr/data/last stable while req is high and gnt is low. Beats presented without a grant are ignored.

## Timing

- Request to grant: gnt rises on the edge after req is first sampled in IDLE, giving 1 cycle of latency.
- Grant handover on a last beat is 0 bubble cycles: the new gnt is high on the cycle after the last beat.
- Write latency: ram_wren, ram_wraddr and ram_data are registered one cycle after the accepted beat. Sustained throughput is 1 write per cycle.
- beat_count increments in the same cycle that ram_wren is high.
- Reset values: state IDLE, rr 0, gnt0/gnt1/busy/ram_wren/err_range/err_timeout 0, ram_wraddr 0, ram_data 0, beat_count 0, idle counter 0.
- Reset mid-burst:
  - All outputs reach their reset values on the next edge.
  - Any write pending in the output register is discarded (ram_wren=0).
  - Requesters restart their bursts from the beginning.
- Simultaneous events:
  - A last beat and the watchdog expiry cannot coincide, because an accepted beat clears the counter.
  - A reset asserted in the same cycle as an accepted beat wins, and no write is issued.

## Structure

- Shared package fb_pkg holds ADDR_W, DATA_W, TOTAL_PIXELS (160*120) and the arbiter state enum (IDLE, OWN0, OWN1). The loader and the processing engine reuse these.
- One sub-module is used: fb_idle_watchdog, a counter with clear/enable inputs, parameter LIMIT, and output expired. All other logic is flat.

## Test plan

- **Single burst:** req0 with addr 0..3 and data 0xA0..0xA3, last on addr 3 → gnt0 one cycle after req, ram_wren for 4 consecutive cycles with the matching addr/data, then IDLE and busy=0; beat_count=4.
- **Contention after reset:** req0 and req1 both asserted in the same cycle after reset → OWN0 first. On last0 the grant passes to OWN1 with no bubble. After last1, with both requesting again, OWN0 is granted.
- **Range filter:** a burst with addr 19199, 19200, 0 → RAM writes only for 19199 and 0; err_range=1 and stays 1 after the burst; beat_count=2.
- **Watchdog:** req0 granted, then req0 held low for 16 cycles while req1 is high → err_timeout=1 and gnt1 rises. req0 deasserted for 15 cycles followed by a beat → no eviction.
- **Back-to-back burst:** requester 0 issues a last beat with req1 low and req0 still high → gnt0 stays high and the next burst is accepted with no gap.
- **Reset mid-burst:** reset asserted for 1 cycle at beat 2 of a 5-beat burst → on the next cycle ram_wren=0, gnt0=0, beat_count=0, state IDLE. A fresh req0 is granted after 1 cycle.
